// File: rtl/xp_pkg.sv
// Shared crosspoint definitions: default port count and arbiter lock states.
package xp_pkg;

   localparam int XP_NUM_PORT = 5;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_LOCK = 1'b1
   } xp_lock_e;

endpackage

// File: rtl/xp_sel_bit_from_vec.sv
// Returns the first set bit of in_vec at or above the one-hot start position,
// wrapping around to bit 0 when nothing is set at or above it.
module xp_sel_bit_from_vec #(
   parameter int VEC_WIDTH = 5
) (
   input  logic [VEC_WIDTH-1:0] in_vec,
   input  logic [VEC_WIDTH-1:0] startx,
   output logic [VEC_WIDTH-1:0] out_vec,
   output logic                 found
);

   localparam logic [VEC_WIDTH-1:0] ONE = {{(VEC_WIDTH-1){1'b0}}, 1'b1};

   logic [VEC_WIDTH-1:0] upper_vec;

   // Bits at or above the start position win first; x & -x isolates the lowest set bit.
   always_comb begin
      upper_vec = in_vec & ~(startx - ONE);
      if (upper_vec != '0) begin
         out_vec = upper_vec & (~upper_vec + ONE);
      end else begin
         out_vec = in_vec & (~in_vec + ONE);
      end
      found = |in_vec;
   end

endmodule

// File: rtl/xp_rr_arb.sv
// Round-robin arbiter for one XP output port; holds the grant for a whole packet
// and only rotates priority once the packet's last flit is accepted.
module xp_rr_arb
   import xp_pkg::*;
#(
   parameter int NUM_REQ = XP_NUM_PORT,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req_vld,
   input  logic [NUM_REQ-1:0] req_last,
   input  logic               out_rdy,
   output logic [NUM_REQ-1:0] gnt,
   output logic               gnt_vld,
   output logic [IDX_W-1:0]   gnt_idx,
   output logic               gnt_last,
   output logic               busy
);

   xp_lock_e           lock_q;
   logic [NUM_REQ-1:0] ptr_q;
   logic [NUM_REQ-1:0] lock_vec_q;
   logic [NUM_REQ-1:0] sel_vec;
   logic               sel_found;
   logic               xfer;
   logic               pkt_done;

   function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] vec);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (vec[i]) idx = idx | IDX_W'(i);
      end
      return idx;
   endfunction

   xp_sel_bit_from_vec #(
      .VEC_WIDTH(NUM_REQ)
   ) u_sel (
      .in_vec (req_vld),
      .startx (ptr_q),
      .out_vec(sel_vec),
      .found  (sel_found)
   );

   // While locked the held grant stays on the output even if its requester bubbles.
   always_comb begin
      if (lock_q == ST_LOCK) begin
         gnt     = lock_vec_q;
         gnt_vld = |(lock_vec_q & req_vld);
      end else begin
         gnt     = sel_vec;
         gnt_vld = sel_found;
      end
      gnt_last = |(gnt & req_last);
      gnt_idx  = onehot_to_idx(gnt);
      busy     = (lock_q == ST_LOCK);
      xfer     = gnt_vld & out_rdy;
      pkt_done = xfer & gnt_last;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lock_q     <= ST_IDLE;
         ptr_q      <= {{(NUM_REQ-1){1'b0}}, 1'b1};
         lock_vec_q <= '0;
      end else begin
         if (pkt_done) begin
            ptr_q <= {gnt[NUM_REQ-2:0], gnt[NUM_REQ-1]};
         end
         case (lock_q)
            ST_IDLE: begin
               if (gnt_vld && !(out_rdy && gnt_last)) begin
                  lock_q     <= ST_LOCK;
                  lock_vec_q <= gnt;
               end
            end
            ST_LOCK: begin
               if (pkt_done) begin
                  lock_q     <= ST_IDLE;
                  lock_vec_q <= '0;
               end
            end
            default: begin
               lock_q     <= ST_IDLE;
               lock_vec_q <= '0;
            end
         endcase
      end
   end

   gnt_onehot0_a: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
   gnt_subset_a:  assert property (@(posedge clk) disable iff (!rst_n)
                                   (lock_q == ST_IDLE) |-> ((gnt & ~req_vld) == '0));
   lock_onehot_a: assert property (@(posedge clk) disable iff (!rst_n)
                                   (lock_q == ST_LOCK) |-> $onehot(lock_vec_q));

endmodule

// File: tb/tb_xp_rr_arb.sv
// Scoreboard bench for xp_rr_arb with NUM_REQ=4: directed scenarios followed by
// randomized valid/ready traffic, all predicted by a packet-level reference model.
module tb_xp_rr_arb;

   localparam int N = 4;

   typedef struct packed {
      logic [N-1:0] gnt;
      logic         gnt_vld;
      logic [1:0]   gnt_idx;
      logic         gnt_last;
      logic         busy;
   } exp_t;

   logic         clk;
   logic         rst_n;
   logic [N-1:0] req_vld;
   logic [N-1:0] req_last;
   logic         out_rdy;
   logic [N-1:0] gnt;
   logic         gnt_vld;
   logic [1:0]   gnt_idx;
   logic         gnt_last;
   logic         busy;

   exp_t sb[$];
   int   n_vec;
   int   n_bad;
   int   m_ptr;
   int   m_owner;
   int   acc_idx;
   int   rem[N];
   logic hold[N];

   xp_rr_arb #(
      .NUM_REQ(N)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req_vld (req_vld),
      .req_last(req_last),
      .out_rdy (out_rdy),
      .gnt     (gnt),
      .gnt_vld (gnt_vld),
      .gnt_idx (gnt_idx),
      .gnt_last(gnt_last),
      .busy    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: priority index m_ptr, packet owner m_owner (-1 when no packet is in flight).
   task automatic applyStimulus(input logic [N-1:0] vld, input logic [N-1:0] last,
                                input logic rdy, input logic rstn);
      exp_t e;
      int   g;
      @(posedge clk);
      #1;
      req_vld  = vld;
      req_last = last;
      out_rdy  = rdy;
      rst_n    = rstn;
      g = -1;
      if (m_owner >= 0) begin
         g = m_owner;
      end else begin
         for (int k = 0; k < N; k++) begin
            if (g < 0 && vld[(m_ptr + k) % N]) g = (m_ptr + k) % N;
         end
      end
      e = '0;
      if (g >= 0) begin
         e.gnt      = N'(1 << g);
         e.gnt_idx  = 2'(g);
         e.gnt_vld  = vld[g];
         e.gnt_last = last[g];
      end
      e.busy = (m_owner >= 0);
      sb.push_back(e);
      acc_idx = (e.gnt_vld && rdy) ? g : -1;
      if (!rstn) begin
         m_ptr   = 0;
         m_owner = -1;
      end else if (e.gnt_vld && rdy && e.gnt_last) begin
         m_ptr   = (g + 1) % N;
         m_owner = -1;
      end else if (m_owner < 0 && e.gnt_vld) begin
         m_owner = g;
      end
   endtask

   task automatic checkOutput(input exp_t e);
      exp_t act;
      act = '{gnt: gnt, gnt_vld: gnt_vld, gnt_idx: gnt_idx, gnt_last: gnt_last, busy: busy};
      n_vec++;
      if (act !== e) begin
         n_bad++;
         $display("[TB] FAIL arb_outputs t=%0t: got gnt=%b vld=%b idx=%0d last=%b busy=%b, expected gnt=%b vld=%b idx=%0d last=%b busy=%b",
                  $time, act.gnt, act.gnt_vld, act.gnt_idx, act.gnt_last, act.busy,
                  e.gnt, e.gnt_vld, e.gnt_idx, e.gnt_last, e.busy);
      end
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) checkOutput(sb.pop_front());
   end

   initial begin
      n_vec    = 0;
      n_bad    = 0;
      acc_idx  = -1;
      rst_n    = 1'b0;
      req_vld  = '0;
      req_last = '0;
      out_rdy  = 1'b0;
      repeat (3) @(posedge clk);
      m_ptr   = 0;
      m_owner = -1;

      // Fairness after reset: all requesters single-flit, always ready.
      repeat (8) applyStimulus(4'b1111, 4'b1111, 1'b1, 1'b1);

      // Move pointer to bit 3, then 0011 must wrap to requester 0, then requester 1.
      applyStimulus(4'b0100, 4'b0100, 1'b1, 1'b1);
      applyStimulus(4'b0011, 4'b0011, 1'b1, 1'b1);
      applyStimulus(4'b0011, 4'b0011, 1'b1, 1'b1);

      // Multi-flit lock on requester 1 with 0 and 2 competing, then 2 wins.
      applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0);
      applyStimulus(4'b0001, 4'b0001, 1'b1, 1'b1);
      applyStimulus(4'b0111, 4'b0000, 1'b1, 1'b1);
      applyStimulus(4'b0111, 4'b0000, 1'b1, 1'b1);
      applyStimulus(4'b0111, 4'b0010, 1'b1, 1'b1);
      applyStimulus(4'b0101, 4'b0101, 1'b1, 1'b1);

      // Stall hold: three cycles without ready, then accept; next winner is requester 2.
      applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0);
      repeat (3) applyStimulus(4'b0101, 4'b0101, 1'b0, 1'b1);
      applyStimulus(4'b0101, 4'b0101, 1'b1, 1'b1);
      applyStimulus(4'b0101, 4'b0101, 1'b1, 1'b1);

      // Bubble: requester 2 locked mid-packet drops valid while requester 3 waits.
      applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0);
      applyStimulus(4'b0100, 4'b0000, 1'b1, 1'b1);
      repeat (2) applyStimulus(4'b1000, 4'b1000, 1'b1, 1'b1);
      applyStimulus(4'b1100, 4'b1100, 1'b1, 1'b1);
      applyStimulus(4'b1000, 4'b1000, 1'b1, 1'b1);

      // Reset while locked on requester 1; afterwards the search restarts from bit 0.
      applyStimulus(4'b0010, 4'b0000, 1'b1, 1'b1);
      applyStimulus(4'b0011, 4'b0000, 1'b1, 1'b0);
      applyStimulus(4'b0011, 4'b0011, 1'b1, 1'b1);
      applyStimulus(4'b0011, 4'b0011, 1'b1, 1'b1);

      // Random packet traffic: a raised valid is held until its flit is accepted.
      for (int i = 0; i < N; i++) begin
         rem[i]  = 0;
         hold[i] = 1'b0;
      end
      for (int c = 0; c < 800; c++) begin
         logic [N-1:0] v;
         logic [N-1:0] l;
         for (int i = 0; i < N; i++) begin
            if (!hold[i]) begin
               if (rem[i] == 0) rem[i] = $urandom_range(1, 3);
               hold[i] = ($urandom_range(0, 2) != 0);
            end
            v[i] = hold[i];
            l[i] = (rem[i] == 1);
         end
         applyStimulus(v, l, ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) != 0));
         if (acc_idx >= 0) begin
            rem[acc_idx]  = rem[acc_idx] - 1;
            hold[acc_idx] = 1'b0;
         end
      end

      for (int t = 0; t < 10 && sb.size() > 0; t++) @(negedge clk);
      @(posedge clk);
      if (sb.size() > 0) begin
         n_vec++;
         n_bad++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
